// File: rtl/wash_if.sv
// wash_if: command, status and counter-link signals between the wash controller and its sequencer
interface wash_if;
  logic       START;
  logic       ABORT;
  logic       PAUSE;
  logic       DOOR_OPEN;
  logic [1:0] MODE;
  logic       TICK;
  logic [7:0] Q;
  logic [7:0] RS;
  logic       LD_;
  logic       M;
  logic       CNT_CP;
  logic       VALVE;
  logic       MOTOR;
  logic       PUMP;
  logic       SPIN_HI;
  logic       DONE_LED;
  logic [2:0] PHASE;
  modport master (
    output START, ABORT, PAUSE, DOOR_OPEN, MODE, TICK, Q,
    input  RS, LD_, M, CNT_CP, VALVE, MOTOR, PUMP, SPIN_HI, DONE_LED, PHASE
  );
  modport slave (
    input  START, ABORT, PAUSE, DOOR_OPEN, MODE, TICK, Q,
    output RS, LD_, M, CNT_CP, VALVE, MOTOR, PUMP, SPIN_HI, DONE_LED, PHASE
  );
endinterface

// File: rtl/wash_sequencer.sv
// wash_sequencer: steps FILL/WASH/RINSE/DRAIN/SPIN phases, timing each with an external down-counter
module wash_sequencer #(
  parameter logic [7:0] T_FILL   = 8'd20,
  parameter logic [7:0] T_WASH_Q = 8'd60,
  parameter logic [7:0] T_WASH_N = 8'd120,
  parameter logic [7:0] T_WASH_H = 8'd200,
  parameter logic [7:0] T_RINSE  = 8'd40,
  parameter logic [7:0] T_DRAIN  = 8'd15,
  parameter logic [7:0] T_SPIN   = 8'd50
) (
  input logic   CP,
  input logic   CLR,
  wash_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    RINSE = 3'd3,
    DRAIN = 3'd4,
    SPIN  = 3'd5,
    DONE  = 3'd6
  } state_t;
  state_t     state, state_nx;
  logic [1:0] mode_q, mode_nx, rinse_cnt, rinse_nx, last_grp;
  logic [7:0] rs_q, rs_nx, wash_t, dur;
  logic [4:0] act_q, act_nx;
  logic       ld_q, ld_nx, cnt_q, cnt_nx;
  logic       running, hold, gate, check, fin, start_ok, enter;
  assign running  = state inside {FILL, WASH, RINSE, DRAIN, SPIN};
  assign gate     = bus.PAUSE || bus.DOOR_OPEN;
  assign hold     = running && gate;
  // Q is only trusted once the load cycle of the current phase has passed
  assign check    = running && ld_q && !hold;
  assign fin      = check && bus.Q == 8'd0;
  assign start_ok = bus.START && !bus.DOOR_OPEN && (state == IDLE || state == DONE);
  // rinse_cnt counts completed FILL..DRAIN groups; last_grp is the group after which SPIN follows
  assign last_grp = mode_q == 2'd3 ? 2'd0 : mode_q == 2'd2 ? 2'd2 : 2'd1;
  assign wash_t   = mode_q == 2'd0 ? T_WASH_Q : mode_q == 2'd2 ? T_WASH_H : T_WASH_N;
  always_comb begin
    state_nx = state;
    mode_nx  = mode_q;
    rinse_nx = rinse_cnt;
    if (bus.ABORT) begin
      state_nx = IDLE;
    end else if (start_ok) begin
      state_nx = FILL;
      mode_nx  = bus.MODE;
      rinse_nx = 2'd0;
    end else if (fin) begin
      case (state)
        FILL:        state_nx = (rinse_cnt == 2'd0 && mode_q != 2'd3) ? WASH : RINSE;
        WASH, RINSE: state_nx = DRAIN;
        DRAIN: begin
          state_nx = rinse_cnt == last_grp ? SPIN : FILL;
          rinse_nx = rinse_cnt + 2'd1;
        end
        SPIN:        state_nx = DONE;
        default:     state_nx = state;
      endcase
    end
  end
  assign enter  = state_nx != state && state_nx inside {FILL, WASH, RINSE, DRAIN, SPIN};
  assign dur    = state_nx == FILL  ? T_FILL  :
                  state_nx == WASH  ? wash_t  :
                  state_nx == RINSE ? T_RINSE :
                  state_nx == DRAIN ? T_DRAIN : T_SPIN;
  assign ld_nx  = !enter;
  assign rs_nx  = enter ? dur : rs_q;
  // a tick that coincides with completion (Q==0) never strobes, so the counter cannot wrap
  assign cnt_nx = bus.TICK && check && bus.Q != 8'd0 && !bus.ABORT;
  assign act_nx = {state_nx == FILL && !gate,
                   state_nx inside {WASH, RINSE, SPIN} && !gate,
                   state_nx inside {DRAIN, SPIN} && !gate,
                   state_nx == SPIN && !gate,
                   state_nx == DONE};
  always_ff @(posedge CP) begin
    if (CLR) begin
      state     <= IDLE;
      mode_q    <= 2'd0;
      rinse_cnt <= 2'd0;
      rs_q      <= 8'd0;
      ld_q      <= 1'b1;
      cnt_q     <= 1'b0;
      act_q     <= 5'd0;
    end else begin
      state     <= state_nx;
      mode_q    <= mode_nx;
      rinse_cnt <= rinse_nx;
      rs_q      <= rs_nx;
      ld_q      <= ld_nx;
      cnt_q     <= cnt_nx;
      act_q     <= act_nx;
    end
  end
  assign bus.RS     = rs_q;
  assign bus.LD_    = ld_q;
  assign bus.M      = 1'b0;
  assign bus.CNT_CP = cnt_q;
  assign bus.PHASE  = state;
  assign {bus.VALVE, bus.MOTOR, bus.PUMP, bus.SPIN_HI, bus.DONE_LED} = act_q;
endmodule

// File: tb/tb_wash_sequencer.sv
// tb_wash_sequencer: directed bench with two sequencers, each driving a modelled 8-bit up/down counter
module tb_wash_sequencer;
  logic       cp = 1'b0, clr = 1'b1, start = 1'b0, abort = 1'b0, pause = 1'b0, door = 1'b0, tick = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] qa = 8'd0, qb = 8'd0;
  int         checks = 0, passes = 0, pulses_a = 0, pulses_b = 0, drain_cyc = 0, drain_pls = 0;
  logic [2:0] ph_a[$], ph_b[$];
  logic [7:0] rs_a[$], rs_b[$];
  logic [2:0] exp_m1 [7]  = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd3, 3'd4, 3'd5};
  logic [2:0] exp_m2 [10] = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd3, 3'd4, 3'd1, 3'd3, 3'd4, 3'd5};
  logic [7:0] rs_m2 [10]  = '{8'd2, 8'd5, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2};
  logic [2:0] exp_m3 [4]  = '{3'd1, 3'd3, 3'd4, 3'd5};
  logic [7:0] rs_m3 [4]   = '{8'd2, 8'd3, 8'd0, 8'd2};
  wash_if ia();
  wash_if ib();
  assign ia.START = start;  assign ib.START = start;
  assign ia.ABORT = abort;  assign ib.ABORT = abort;
  assign ia.PAUSE = pause;  assign ib.PAUSE = pause;
  assign ia.DOOR_OPEN = door; assign ib.DOOR_OPEN = door;
  assign ia.MODE = mode;    assign ib.MODE = mode;
  assign ia.TICK = tick;    assign ib.TICK = tick;
  assign ia.Q = qa;         assign ib.Q = qb;
  wash_sequencer #(.T_FILL(8'd2), .T_WASH_Q(8'd2), .T_WASH_N(8'd2), .T_WASH_H(8'd5),
                   .T_RINSE(8'd2), .T_DRAIN(8'd2), .T_SPIN(8'd2))
    u_a (.CP(cp), .CLR(clr), .bus(ia));
  wash_sequencer #(.T_FILL(8'd2), .T_WASH_Q(8'd2), .T_WASH_N(8'd2), .T_WASH_H(8'd2),
                   .T_RINSE(8'd3), .T_DRAIN(8'd0), .T_SPIN(8'd2))
    u_b (.CP(cp), .CLR(clr), .bus(ib));
  always #5 cp = ~cp;
  // counter models: load on LD_ low, step on CNT_CP; new value visible from the following cycle
  always @(posedge cp) begin
    if (!ia.LD_) begin
      qa <= ia.RS;
      ph_a.push_back(ia.PHASE);
      rs_a.push_back(ia.RS);
    end else if (ia.CNT_CP) qa <= ia.M ? qa + 8'd1 : qa - 8'd1;
    if (ia.CNT_CP) pulses_a++;
    if (!ib.LD_) begin
      qb <= ib.RS;
      ph_b.push_back(ib.PHASE);
      rs_b.push_back(ib.RS);
    end else if (ib.CNT_CP) qb <= ib.M ? qb + 8'd1 : qb - 8'd1;
    if (ib.CNT_CP) pulses_b++;
  end
  always @(negedge cp) begin
    if (ib.PHASE == 3'd4) begin
      drain_cyc++;
      if (ib.CNT_CP) drain_pls++;
    end
  end
  task automatic clear_logs();
    ph_a.delete(); rs_a.delete(); ph_b.delete(); rs_b.delete();
    pulses_a = 0; pulses_b = 0; drain_cyc = 0; drain_pls = 0;
  endtask
  task automatic do_reset();
    clr = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0; door = 1'b0; tick = 1'b0;
    @(negedge cp);
    clr = 1'b0;
    clear_logs();
  endtask
  task automatic start_prog(input logic [1:0] m);
    mode = m; start = 1'b1;
    @(negedge cp);
    start = 1'b0;
  endtask
  task automatic tick_until(input bit b, input logic [2:0] tgt, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      tick = (i % 4 == 0);
      @(negedge cp);
      ok = ((b ? ib.PHASE : ia.PHASE) == tgt);
    end
    tick = 1'b0;
  endtask
  task automatic test_reset();
    clr = 1'b1; start = 1'b1; tick = 1'b1; mode = 2'd1;
    @(negedge cp);
    checks++; if (ia.PHASE !== 3'd0) $display("FAIL reset_phase: got %0d expected 0", ia.PHASE); else passes++;
    checks++; if (ia.RS !== 8'd0) $display("FAIL reset_rs: got %0d expected 0", ia.RS); else passes++;
    checks++; if (ia.LD_ !== 1'b1 || ia.M !== 1'b0 || ia.CNT_CP !== 1'b0)
      $display("FAIL reset_ctl: got LD_=%b M=%b CNT_CP=%b expected 1 0 0", ia.LD_, ia.M, ia.CNT_CP); else passes++;
    checks++; if ({ia.VALVE, ia.MOTOR, ia.PUMP, ia.SPIN_HI, ia.DONE_LED} !== 5'b0)
      $display("FAIL reset_act: got %b expected 00000", {ia.VALVE, ia.MOTOR, ia.PUMP, ia.SPIN_HI, ia.DONE_LED}); else passes++;
    clr = 1'b0; start = 1'b0; tick = 1'b0;
  endtask
  task automatic test_mode1();
    bit ok;
    do_reset();
    start_prog(2'd1);
    checks++; if (ia.PHASE !== 3'd1 || ia.LD_ !== 1'b0 || ia.RS !== 8'd2 || ia.VALVE !== 1'b1)
      $display("FAIL m1_entry: got PHASE=%0d LD_=%b RS=%0d VALVE=%b expected 1 0 2 1", ia.PHASE, ia.LD_, ia.RS, ia.VALVE); else passes++;
    @(negedge cp);
    checks++; if (ia.LD_ !== 1'b1) $display("FAIL m1_ld_release: got %b expected 1", ia.LD_); else passes++;
    tick_until(1'b0, 3'd6, 400, ok);
    checks++; if (!ok) $display("FAIL m1_reach_done: got PHASE=%0d expected 6", ia.PHASE); else passes++;
    checks++; if (ph_a.size() != 7) $display("FAIL m1_entries: got %0d expected 7", ph_a.size()); else passes++;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (ph_a[i] !== exp_m1[i] || rs_a[i] !== 8'd2)
        $display("FAIL m1_seq[%0d]: got PHASE=%0d RS=%0d expected %0d 2", i, ph_a[i], rs_a[i], exp_m1[i]);
      else passes++;
    end
    checks++; if (pulses_a != 14) $display("FAIL m1_pulses: got %0d expected 14", pulses_a); else passes++;
    repeat (5) @(negedge cp);
    checks++; if ({ia.VALVE, ia.MOTOR, ia.PUMP, ia.SPIN_HI, ia.DONE_LED} !== 5'b00001)
      $display("FAIL m1_done_led: got %b expected 00001", {ia.VALVE, ia.MOTOR, ia.PUMP, ia.SPIN_HI, ia.DONE_LED}); else passes++;
  endtask
  task automatic test_mode2();
    bit ok;
    clear_logs();
    start_prog(2'd2);
    checks++; if (ia.PHASE !== 3'd1 || ia.DONE_LED !== 1'b0)
      $display("FAIL m2_restart_from_done: got PHASE=%0d DONE_LED=%b expected 1 0", ia.PHASE, ia.DONE_LED); else passes++;
    tick_until(1'b0, 3'd6, 600, ok);
    checks++; if (!ok) $display("FAIL m2_reach_done: got PHASE=%0d expected 6", ia.PHASE); else passes++;
    checks++; if (ph_a.size() != 10) $display("FAIL m2_entries: got %0d expected 10", ph_a.size()); else passes++;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (ph_a[i] !== exp_m2[i] || rs_a[i] !== rs_m2[i])
        $display("FAIL m2_seq[%0d]: got PHASE=%0d RS=%0d expected %0d %0d", i, ph_a[i], rs_a[i], exp_m2[i], rs_m2[i]);
      else passes++;
    end
    checks++; if (pulses_a != 23) $display("FAIL m2_pulses: got %0d expected 23", pulses_a); else passes++;
  endtask
  task automatic test_pause();
    bit ok;
    int viol, nt;
    do_reset();
    start_prog(2'd2);
    tick_until(1'b0, 3'd2, 200, ok);
    checks++; if (!ok) $display("FAIL pause_reach_wash: got PHASE=%0d expected 2", ia.PHASE); else passes++;
    repeat (3) @(negedge cp);
    checks++; if (qa !== 8'd5 || ia.MOTOR !== 1'b1)
      $display("FAIL pause_pre: got Q=%0d MOTOR=%b expected 5 1", qa, ia.MOTOR); else passes++;
    pause = 1'b1;
    viol = 0;
    for (int i = 0; i < 40; i++) begin
      tick = (i % 4 == 0);
      @(negedge cp);
      if (ia.MOTOR !== 1'b0 || ia.CNT_CP !== 1'b0 || qa !== 8'd5 || ia.PHASE !== 3'd2) viol++;
    end
    tick = 1'b0;
    checks++; if (viol != 0) $display("FAIL pause_hold: got %0d bad cycles expected 0", viol); else passes++;
    pause = 1'b0;
    nt = 0; ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick = (i % 4 == 0);
      if (tick) nt++;
      @(negedge cp);
      ok = (ia.PHASE == 3'd4);
    end
    tick = 1'b0;
    checks++; if (!ok || nt != 5) $display("FAIL pause_resume_ticks: got %0d reached=%b expected 5 1", nt, ok); else passes++;
  endtask
  task automatic test_door_idle();
    do_reset();
    door = 1'b1;
    start_prog(2'd1);
    checks++; if (ia.PHASE !== 3'd0 || ia.VALVE !== 1'b0)
      $display("FAIL door_idle_start: got PHASE=%0d VALVE=%b expected 0 0", ia.PHASE, ia.VALVE); else passes++;
    @(negedge cp);
    checks++; if (ia.PHASE !== 3'd0) $display("FAIL door_idle_stay: got %0d expected 0", ia.PHASE); else passes++;
    door = 1'b0;
  endtask
  task automatic test_door_spin();
    bit ok;
    do_reset();
    start_prog(2'd1);
    tick_until(1'b0, 3'd5, 400, ok);
    checks++; if (!ok) $display("FAIL spin_reach: got PHASE=%0d expected 5", ia.PHASE); else passes++;
    checks++; if ({ia.PUMP, ia.MOTOR, ia.SPIN_HI} !== 3'b111)
      $display("FAIL spin_act: got %b expected 111", {ia.PUMP, ia.MOTOR, ia.SPIN_HI}); else passes++;
    door = 1'b1;
    @(negedge cp);
    checks++; if ({ia.PUMP, ia.MOTOR, ia.SPIN_HI} !== 3'b000 || ia.PHASE !== 3'd5)
      $display("FAIL spin_door: got act=%b PHASE=%0d expected 000 5", {ia.PUMP, ia.MOTOR, ia.SPIN_HI}, ia.PHASE); else passes++;
    door = 1'b0;
    @(negedge cp);
    checks++; if ({ia.PUMP, ia.MOTOR, ia.SPIN_HI} !== 3'b111)
      $display("FAIL spin_door_release: got %b expected 111", {ia.PUMP, ia.MOTOR, ia.SPIN_HI}); else passes++;
  endtask
  task automatic test_mode3_drain0();
    bit ok;
    do_reset();
    start_prog(2'd3);
    tick_until(1'b1, 3'd6, 400, ok);
    checks++; if (!ok) $display("FAIL m3_reach_done: got PHASE=%0d expected 6", ib.PHASE); else passes++;
    checks++; if (ph_b.size() != 4) $display("FAIL m3_entries: got %0d expected 4", ph_b.size()); else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ph_b[i] !== exp_m3[i] || rs_b[i] !== rs_m3[i])
        $display("FAIL m3_seq[%0d]: got PHASE=%0d RS=%0d expected %0d %0d", i, ph_b[i], rs_b[i], exp_m3[i], rs_m3[i]);
      else passes++;
    end
    checks++; if (pulses_b != 7) $display("FAIL m3_pulses: got %0d expected 7", pulses_b); else passes++;
    checks++; if (drain_cyc != 2 || drain_pls != 0)
      $display("FAIL drain0_len: got cycles=%0d pulses=%0d expected 2 0", drain_cyc, drain_pls); else passes++;
  endtask
  task automatic test_abort();
    bit ok;
    do_reset();
    start_prog(2'd1);
    tick_until(1'b0, 3'd3, 400, ok);
    checks++; if (!ok) $display("FAIL abort_reach_rinse: got PHASE=%0d expected 3", ia.PHASE); else passes++;
    @(negedge cp);
    checks++; if (ia.MOTOR !== 1'b1) $display("FAIL abort_pre_motor: got %b expected 1", ia.MOTOR); else passes++;
    abort = 1'b1; tick = 1'b1;
    @(negedge cp);
    abort = 1'b0; tick = 1'b0;
    checks++; if (ia.PHASE !== 3'd0 || {ia.VALVE, ia.MOTOR, ia.PUMP, ia.SPIN_HI, ia.DONE_LED} !== 5'b0 || ia.LD_ !== 1'b1 || ia.CNT_CP !== 1'b0)
      $display("FAIL abort_idle: got PHASE=%0d act=%b LD_=%b CNT_CP=%b expected 0 00000 1 0", ia.PHASE,
               {ia.VALVE, ia.MOTOR, ia.PUMP, ia.SPIN_HI, ia.DONE_LED}, ia.LD_, ia.CNT_CP); else passes++;
    @(negedge cp);
    checks++; if (ia.PHASE !== 3'd0) $display("FAIL abort_stay: got %0d expected 0", ia.PHASE); else passes++;
  endtask
  task automatic test_clr_priority();
    bit ok;
    do_reset();
    start_prog(2'd1);
    tick_until(1'b0, 3'd2, 200, ok);
    checks++; if (!ok) $display("FAIL clr_reach_wash: got PHASE=%0d expected 2", ia.PHASE); else passes++;
    repeat (3) @(negedge cp);
    clr = 1'b1; tick = 1'b1; start = 1'b1;
    @(negedge cp);
    clr = 1'b0; tick = 1'b0; start = 1'b0;
    checks++; if (ia.PHASE !== 3'd0 || ia.RS !== 8'd0 || ia.LD_ !== 1'b1 || ia.CNT_CP !== 1'b0 ||
                  {ia.VALVE, ia.MOTOR, ia.PUMP, ia.SPIN_HI, ia.DONE_LED} !== 5'b0)
      $display("FAIL clr_mid: got PHASE=%0d RS=%0d LD_=%b CNT_CP=%b act=%b expected 0 0 1 0 00000", ia.PHASE, ia.RS,
               ia.LD_, ia.CNT_CP, {ia.VALVE, ia.MOTOR, ia.PUMP, ia.SPIN_HI, ia.DONE_LED}); else passes++;
    @(negedge cp);
    checks++; if (ia.PHASE !== 3'd0 || ia.LD_ !== 1'b1)
      $display("FAIL clr_no_reload: got PHASE=%0d LD_=%b expected 0 1", ia.PHASE, ia.LD_); else passes++;
  endtask
  initial begin
    test_reset();
    test_mode1();
    test_mode2();
    test_pause();
    test_door_idle();
    test_door_spin();
    test_mode3_drain0();
    test_abort();
    test_clr_priority();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/wash_sequencer.md
# wash_sequencer

Program sequencer for the washing-machine controller, directly upstream of the 8-bit loadable up/down phase counter. It steps through FILL, WASH, DRAIN, RINSE and SPIN phases. For each phase it loads the counter with a duration and clocks it down once per accepted second tick. It reads the counter value back to detect phase completion, drives the actuator enables, and handles pause, door-open and abort.

## Interface
- T_FILL, 8'd20: FILL duration in ticks.
- T_WASH_Q / T_WASH_N / T_WASH_H, 8'd60 / 8'd120 / 8'd200: WASH duration for quick / normal / heavy.
- T_RINSE, 8'd40: RINSE duration.
- T_DRAIN, 8'd15: DRAIN duration.
- T_SPIN, 8'd50: SPIN duration.
- CP  in  1  system clock, rising edge.
- CLR  in  1  synchronous reset, active-high.
- START  in  1  one-cycle start request.
- ABORT  in  1  synchronous abort to IDLE.
- PAUSE  in  1  level; holds program.
- DOOR_OPEN  in  1  level; treated as PAUSE while running, blocks START.
- MODE  in  2  0 quick, 1 normal, 2 heavy, 3 rinse-only; latched on accepted START.
- TICK  in  1  one-cycle 1 Hz strobe, CP-synchronous.
- Q  in  8  counter value, read back.
- RS  out  8  load value to counter.
- LD_  out  1  active-low counter load.
- M  out  1  counter direction; constant 0 (down).
- CNT_CP  out  1  counter clock strobe.
- VALVE, MOTOR, PUMP, SPIN_HI, DONE_LED  out  1 each  actuator/indicator enables.
- PHASE  out  3  current state code.

## Operation
- States and PHASE codes: IDLE=0, FILL=1, WASH=2, RINSE=3, DRAIN=4, SPIN=5, DONE=6.
- Start:
  - START is accepted in IDLE or DONE when DOOR_OPEN=0. It latches MODE and clears RINSE_CNT.
  - START in any other state is ignored.
  - START with DOOR_OPEN=1 is ignored.
- Sequence for modes 0 and 1: FILL, WASH, DRAIN, FILL, RINSE, DRAIN, SPIN, DONE.
- Mode 2 repeats the FILL, RINSE, DRAIN group once more, giving two RINSE phases. RINSE_CNT tracks the repeat.
- Mode 3 skips the first FILL, WASH, DRAIN group: FILL, RINSE, DRAIN, SPIN, DONE.
- The WASH duration is selected by the latched MODE.
- Phase entry:
  - The first cycle in a phase drives LD_=0 and RS=duration.
  - LD_=1 in all other cycles.
- Completion:
  - Q is evaluated at each CP edge in a running phase whose preceding cycle had LD_=1.
  - Q==0 at such an edge advances the state.
  - A phase with duration 0 therefore lasts exactly 2 cycles.
- Count strobe:
  - CNT_CP=1 for exactly one cycle following an edge with TICK=1.
  - That edge must also satisfy all of: running phase, not paused, preceding-cycle LD_=1, Q!=0.
  - Q never wraps 0 to 255.
- Paused means PAUSE=1 or DOOR_OPEN=1 while running. Effects:
  - State, RINSE_CNT and counter hold.
  - TICKs are discarded, not queued.
  - VALVE, MOTOR and PUMP are forced to 0.
  - PHASE is unchanged.
- Actuators when not paused:
  - FILL: VALVE.
  - WASH and RINSE: MOTOR.
  - DRAIN: PUMP.
  - SPIN: PUMP, MOTOR, SPIN_HI.
  - DONE: DONE_LED.
  - IDLE: all 0.
- ABORT in any state goes to IDLE next cycle with all actuators 0. ABORT has priority over START, PAUSE and completion.
- CLR has priority over everything.
- Simultaneous completion and PAUSE: PAUSE wins and the phase holds.
- Simultaneous completion and TICK: the advance occurs and CNT_CP stays 0.

## Timing
- All outputs are registered.
- Reset values: PHASE=0, RS=0, LD_=1, M=0, CNT_CP=0, VALVE=MOTOR=PUMP=SPIN_HI=DONE_LED=0. RINSE_CNT=0 and latched MODE=0.
- Reset mid-phase: the next cycle is IDLE and the counter is not reloaded. Q is left as-is and is ignored until the next phase load.
- START at edge E0:
  - Cycle E0..E1: PHASE=1, LD_=0, RS=T_FILL, VALVE=1.
  - First Q check at E2.
- A TICK sampled at edge En produces CNT_CP during cycle En..En+1.
- The counter decrements on the CNT_CP rising edge. The new Q is sampled at En+2.
- Phase length with N ticks at spacing >= 3 cycles: ends at the first check edge after the N-th CNT_CP pulse plus one edge.
- DONE_LED asserts in the cycle after leaving SPIN. It holds until START, ABORT or CLR.

## Test plan
- Reset, then mode 1 with all durations overridden to 2 and TICK every 4 cycles:
  - PHASE visits 1,2,4,1,3,4,5,6.
  - RS per entry matches the parameter.
  - Exactly 14 CNT_CP pulses.
  - DONE_LED=1 at end.
- Mode 3 with T_RINSE=3: PHASE sequence 1,3,4,5,6. WASH never entered.
- Mode 2: two RINSE entries with RS=T_RINSE each.
- WASH entered with Q=5, PAUSE=1 for 10 TICKs, then released:
  - During pause: MOTOR=0, Q stays 5, no CNT_CP.
  - After release, 5 further TICKs complete the phase.
- DOOR_OPEN=1 during IDLE plus START: PHASE stays 0.
- DOOR_OPEN=1 mid-SPIN: PUMP, MOTOR and SPIN_HI all drop to 0 on the next cycle.
- T_DRAIN=0: DRAIN lasts 2 cycles with no CNT_CP.
- ABORT mid-RINSE: PHASE=0 and all actuators 0 next cycle.
- CLR asserted with TICK and START in the same cycle: all reset values next cycle.
